serial_subtractor_8bit: RTL and testbench
=========================================

Name: serial_subtractor_8bit

Overview:
Bit-serial two's-complement subtractor that computes diff = a - b, one bit per clock, LSB first, using a single borrow-ripple stage. It is the inverse operation of the team's 8-bit ripple-carry adder and serves as the area-lean SUB path of the ALU. A start/busy/done handshake sequences it, and it reports borrow, signed overflow and zero flags.

Parameters:
WIDTH, 8, operand and result width in bits; WIDTH >= 2.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
busy  output  1  high while bits are being processed (state SHIFT)
done  output  1  single-cycle pulse; results valid and updated
diff  output  WIDTH  a - b mod 2^WIDTH; held until the next completion
borrow_out  output  1  1 when unsigned a < b
overflow  output  1  signed overflow of a - b
zero  output  1  1 when diff == 0

Behaviour:
- Reset is asynchronous on the falling edge of rst_n and is released synchronously to clk.
- During reset: state = IDLE. busy, done, diff, borrow_out, overflow and zero are all 0. Internal shift registers, borrow flop and bit counter are 0.
- States:
  - IDLE -> SHIFT on a clk edge with start=1. On that edge: latch a and b into shift registers, clear the borrow flop, clear the bit counter (width ceil(log2 WIDTH)).
  - SHIFT: each edge processes bit i = counter, LSB first.
    - d_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d_i shifts into the result register from the MSB end; the operand registers shift right; the counter increments.
    - On the edge processing bit WIDTH-1: go to DONE. On that same edge, load the outputs:
      - diff <= full result
      - borrow_out <= final br_next
      - overflow <= (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands
      - zero <= (diff == 0)
  - DONE -> IDLE unconditionally on the next edge. done = 1 only while in DONE.
- Latency: start is accepted at edge E0. Outputs update and done rises at edge E(WIDTH). done falls at E(WIDTH+1). With WIDTH=8, the result appears 8 cycles after acceptance.
- busy = 1 exactly in SHIFT, for WIDTH cycles. busy and done are never high together.
- start is ignored in SHIFT and in DONE. There is no queuing. The earliest re-accept is the edge after done falls, so back-to-back throughput is one result per WIDTH+2 cycles.
- Changes on a and b after acceptance do not affect the running operation.
- The visible outputs (diff and the three flags) change only at completion edges. Partial results are never visible.
- Reset asserted mid-operation aborts the operation immediately. All outputs clear to 0. No done is issued.

Test Plan:
1. Reset, then start with a=100, b=37 -> done after 8 cycles; diff=63, borrow_out=0, overflow=0, zero=0; busy high for exactly 8 cycles.
2. a=5, b=10 -> diff=251 (0xFB), borrow_out=1, overflow=0, zero=0. Also a=0x55, b=0x55 -> diff=0, zero=1, borrow_out=0.
3. Signed overflow:
   - a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow_out=0.
   - a=0x7F, b=0xFF -> diff=0x80, overflow=1, borrow_out=1.
4. Pulse start=1 with a=9, b=9 during cycle 3 of a running 100-37 operation, and change a and b mid-run -> the operation is unaffected: diff=63 and only one done pulse.
5. Drop rst_n at cycle 4 of an operation -> all outputs 0 immediately, no done. Then start a=0, b=1 -> diff=0xFF, borrow_out=1, overflow=0.
6. Hold start=1 continuously with a=200, b=55 -> done pulses every 10 cycles with diff=145 each time; outputs stay stable between pulses.

Source files
------------

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// LSB first, through a single borrow-ripple stage. A start/busy/done
// handshake sequences it; borrow, signed overflow and zero flags are
// reported with the result. All visible outputs come straight from flops.
module serial_subtractor_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             a_bit_s;
  logic             b_bit_s;
  logic             d_bit_s;
  logic             br_nx_s;
  logic [WIDTH-1:0] res_nx_s;

  // One borrow-ripple stage on the current LSBs of the operand shifters.
  always_comb begin
    a_bit_s  = a_sh_q[0];
    b_bit_s  = b_sh_q[0];
    d_bit_s  = a_bit_s ^ b_bit_s ^ br_q;
    br_nx_s  = (~a_bit_s & b_bit_s) | (~(a_bit_s ^ b_bit_s) & br_q);
    res_nx_s = {d_bit_s, res_q[WIDTH-1:1]};
  end

  // Next-state logic: operand capture, bit stepping and result publication.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = 1'b0;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d  = res_nx_s;
        br_d   = br_nx_s;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // On the last bit the shifter LSBs hold the latched operand MSBs.
          state_d  = ST_DONE;
          diff_d   = res_nx_s;
          borrow_d = br_nx_s;
          ovf_d    = (a_bit_s != b_bit_s) && (d_bit_s != a_bit_s);
          zero_d   = (res_nx_s == {WIDTH{1'b0}});
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      br_q     <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Self-checking bench for serial_subtractor_8bit: directed plan steps plus
// randomized operands, checked against plain-arithmetic expectations.
module tb_serial_subtractor_8bit;

  logic       clk;
  logic       rst_n;
  logic       start_s;
  logic [7:0] a_s;
  logic [7:0] b_s;
  logic       busy_s;
  logic       done_s;
  logic [7:0] diff_s;
  logic       borrow_s;
  logic       ovf_s;
  logic       zero_s;

  int checks;
  int failures;

  serial_subtractor_8bit #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_s),
    .a          (a_s),
    .b          (b_s),
    .busy       (busy_s),
    .done       (done_s),
    .diff       (diff_s),
    .borrow_out (borrow_s),
    .overflow   (ovf_s),
    .zero       (zero_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [7:0] m_diff(input logic [7:0] x, input logic [7:0] y);
    int r;
    r = (int'(x) - int'(y) + 256) % 256;
    return 8'(r);
  endfunction

  function automatic logic m_ovf(input logic [7:0] x, input logic [7:0] y);
    int sx, sy, r;
    sx = (int'(x) >= 128) ? int'(x) - 256 : int'(x);
    sy = (int'(y) >= 128) ? int'(y) - 256 : int'(y);
    r  = sx - sy;
    return (r > 127 || r < -128) ? 1'b1 : 1'b0;
  endfunction

  task automatic check_result(input string tag, input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] ed;
    ed = m_diff(av, bv);
    check({tag, ".diff"},   32'(diff_s),   32'(ed));
    check({tag, ".borrow"}, 32'(borrow_s), 32'((int'(av) < int'(bv)) ? 1 : 0));
    check({tag, ".ovf"},    32'(ovf_s),    32'(m_ovf(av, bv)));
    check({tag, ".zero"},   32'(zero_s),   32'((ed == 8'd0) ? 1 : 0));
  endtask

  // One full operation; optionally disturbs start/a/b mid-run.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv, input bit disturb);
    int lat, busy_cnt, extra;
    bit seen;
    @(negedge clk);
    start_s = 1'b1; a_s = av; b_s = bv;
    @(posedge clk); #1;
    start_s = 1'b0;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      if (busy_s) busy_cnt++;
      if (disturb && lat == 2) begin
        start_s = 1'b1; a_s = 8'd9; b_s = 8'd9;
      end else if (disturb && lat == 3) begin
        start_s = 1'b0; a_s = 8'($urandom); b_s = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (done_s) seen = 1'b1;
    end
    check({tag, ".done_seen"}, 32'(seen), 32'(1));
    check({tag, ".latency"}, 32'(lat), 32'(8));
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(8));
    check({tag, ".busy_at_done"}, 32'(busy_s), 32'(0));
    check_result(tag, av, bv);
    @(posedge clk); #1;
    check({tag, ".done_fall"}, 32'(done_s), 32'(0));
    if (disturb) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (done_s) extra++;
      end
      check({tag, ".extra_done"}, 32'(extra), 32'(0));
      check_result({tag, ".held"}, av, bv);
    end
  endtask

  initial begin
    int ndone, cyc, t1, t2, t3;
    checks = 0; failures = 0;
    rst_n = 1'b0; start_s = 1'b0; a_s = 8'd0; b_s = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy_s), 32'(0));
    check("rst.done", 32'(done_s), 32'(0));
    check("rst.diff", 32'(diff_s), 32'(0));
    check("rst.flags", 32'({borrow_s, ovf_s, zero_s}), 32'(0));
    @(negedge clk); rst_n = 1'b1;

    run_op("t1_100_37", 8'd100, 8'd37, 1'b0);
    run_op("t2_5_10", 8'd5, 8'd10, 1'b0);
    run_op("t2_55_55", 8'h55, 8'h55, 1'b0);
    run_op("t3_80_01", 8'h80, 8'h01, 1'b0);
    run_op("t3_7f_ff", 8'h7F, 8'hFF, 1'b0);
    run_op("t4_disturb", 8'd100, 8'd37, 1'b1);

    // Reset in the middle of an operation.
    @(negedge clk);
    start_s = 1'b1; a_s = 8'd200; b_s = 8'd55;
    @(posedge clk); #1;
    start_s = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5.busy", 32'(busy_s), 32'(0));
    check("t5.done", 32'(done_s), 32'(0));
    check("t5.diff", 32'(diff_s), 32'(0));
    check("t5.flags", 32'({borrow_s, ovf_s, zero_s}), 32'(0));
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) rst_n = 1'b1;
      if (done_s) ndone++;
    end
    check("t5.no_done", 32'(ndone), 32'(0));
    run_op("t5_0_1", 8'd0, 8'd1, 1'b0);

    // Randomized operands.
    for (int i = 0; i < 16; i++) begin
      run_op("rand", 8'($urandom), 8'($urandom), 1'b0);
    end

    // Start held high continuously.
    @(negedge clk);
    start_s = 1'b1; a_s = 8'd200; b_s = 8'd55;
    ndone = 0; cyc = 0; t1 = 0; t2 = 0; t3 = 0;
    while (ndone < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (done_s) begin
        ndone++;
        if (ndone == 1) t1 = cyc;
        else if (ndone == 2) t2 = cyc;
        else t3 = cyc;
        check("t6.busy_done_excl", 32'(busy_s), 32'(0));
      end
      if (ndone > 0) begin
        check("t6.diff_stable", 32'(diff_s), 32'(145));
        check("t6.flags_stable", 32'({borrow_s, ovf_s, zero_s}), 32'(3'b000));
      end
    end
    check("t6.pulses", 32'(ndone), 32'(3));
    check("t6.first_latency", 32'(t1), 32'(9));
    check("t6.period12", 32'(t2 - t1), 32'(10));
    check("t6.period23", 32'(t3 - t2), 32'(10));
    start_s = 1'b0;
    repeat (12) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
